// File: rtl/bus_arbiter_2m.sv
// ---------------------------------------------------------------------------
// bus_arbiter_2m
//
// Two-master system bus arbiter. It sits between two request generators and
// the shared address/data bus. It decides which master owns the bus, drives
// registered, mutually exclusive grants, supports split transactions (a slave
// parks the current owner and later lets it resume) and forces a release when
// a grant is held for too long without a completion.
//
// Optional feature (compile-time macro BUS_ARB_ROUND_ROBIN_EN):
//   defined   - a simultaneous request goes to the master that was not
//               granted most recently (last_owner resets to M2, so M1 wins
//               the first tie). A split re-grant still takes precedence.
//   undefined - fixed priority, M1 wins a simultaneous request.
//
// Parameters:
//   TIMEOUT_CYCLES - max consecutive granted cycles without m_done (2..65535)
//   CNT_W          - timeout counter width, must hold TIMEOUT_CYCLES-1
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   m1_req       in   master 1 request, held high for the whole transfer
//   m2_req       in   master 2 request
//   m_done       in   one-cycle pulse from the granted master: transfer done
//   split_req    in   one-cycle pulse from the slave: park the current owner
//   split_done   in   one-cycle pulse from the slave: parked master may resume
//   m1_grant     out  master 1 owns the bus
//   m2_grant     out  master 2 owns the bus
//   owner        out  00 none, 01 M1, 10 M2 (never 11)
//   busy         out  any grant active or a split outstanding
//   timeout_err  out  one-cycle pulse on a forced release
// ---------------------------------------------------------------------------
module bus_arbiter_2m #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m1_req,
    input  logic       m2_req,
    input  logic       m_done,
    input  logic       split_req,
    input  logic       split_done,
    output logic       m1_grant,
    output logic       m2_grant,
    output logic [1:0] owner,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StGntM1 = 2'b01,
        StGntM2 = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic             split_pend_q, split_pend_d;
    logic             split_id_q, split_id_d;   // 0 = M1 parked, 1 = M2 parked
    logic             split_ok_q, split_ok_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_err_d;
    logic             m1_elig, m2_elig;
    logic             granted_req;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic             last_owner_q, last_owner_d;  // 0 = M1, 1 = M2
`endif

    // A parked master's request is ignored until its re-grant.
    assign m1_elig = m1_req & ~(split_pend_q & ~split_id_q);
    assign m2_elig = m2_req & ~(split_pend_q & split_id_q);

    always_comb begin
        state_d       = state_q;
        split_pend_d  = split_pend_q;
        split_id_d    = split_id_q;
        split_ok_d    = split_ok_q;
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
        granted_req   = 1'b0;

        // split_done only matters while a master is parked.
        if (split_done && split_pend_q) begin
            split_ok_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (split_pend_q && split_ok_q) begin
                    // Resumed master pre-empts everyone, whatever its req.
                    state_d      = split_id_q ? StGntM2 : StGntM1;
                    split_pend_d = 1'b0;
                    split_ok_d   = 1'b0;
                end else if (m1_elig && m2_elig) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
                    state_d = last_owner_q ? StGntM1 : StGntM2;
`else
                    state_d = StGntM1;
`endif
                end else if (m1_elig) begin
                    state_d = StGntM1;
                end else if (m2_elig) begin
                    state_d = StGntM2;
                end
                if (state_d != StIdle) begin
                    cnt_d = '0;
                end
            end
            StGntM1, StGntM2: begin
                granted_req = (state_q == StGntM1) ? m1_req : m2_req;
                // Release priority: m_done, then split, then req drop,
                // then timeout. The counter holds its value on release.
                if (m_done) begin
                    state_d = StIdle;
                end else if (split_req && !split_pend_q) begin
                    state_d      = StIdle;
                    split_pend_d = 1'b1;
                    split_id_d   = (state_q == StGntM2);
                end else if (!granted_req) begin
                    state_d = StIdle;
                end else if (cnt_q == CntMax) begin
                    state_d       = StIdle;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef BUS_ARB_ROUND_ROBIN_EN
        last_owner_d = last_owner_q;
        if (state_q == StIdle && state_d == StGntM1) begin
            last_owner_d = 1'b0;
        end else if (state_q == StIdle && state_d == StGntM2) begin
            last_owner_d = 1'b1;
        end
`endif
    end

    // All outputs are registered from the next-state values so they change
    // only at the clock edge (or asynchronously on reset).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            split_pend_q <= 1'b0;
            split_id_q   <= 1'b0;
            split_ok_q   <= 1'b0;
            cnt_q        <= '0;
            m1_grant     <= 1'b0;
            m2_grant     <= 1'b0;
            owner        <= 2'b00;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            last_owner_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            split_pend_q <= split_pend_d;
            split_id_q   <= split_id_d;
            split_ok_q   <= split_ok_d;
            cnt_q        <= cnt_d;
            m1_grant     <= (state_d == StGntM1);
            m2_grant     <= (state_d == StGntM2);
            owner        <= {state_d == StGntM2, state_d == StGntM1};
            busy         <= (state_d != StIdle) | split_pend_d;
            timeout_err  <= timeout_err_d;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter_2m
//
// Directed bench for bus_arbiter_2m (TIMEOUT_CYCLES = 8). A transaction-level
// model tracks who owns the bus, how many cycles it has held it, which master
// is parked and whether it may resume; one process compares every DUT output
// against that model on each falling edge. Directed literal checks pin the
// model at the interesting points.
// ---------------------------------------------------------------------------
module tb_bus_arbiter_2m;

    localparam int Tmo = 8;

    logic       clk;
    logic       reset;
    logic       m1_req, m2_req, m_done, split_req, split_done;
    logic       m1_grant, m2_grant, busy, timeout_err;
    logic [1:0] owner;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b1;

    bus_arbiter_2m #(
        .TIMEOUT_CYCLES(Tmo),
        .CNT_W         (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m1_req     (m1_req),
        .m2_req     (m2_req),
        .m_done     (m_done),
        .split_req  (split_req),
        .split_done (split_done),
        .m1_grant   (m1_grant),
        .m2_grant   (m2_grant),
        .owner      (owner),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ model ----
    // own: 0 none, 1 M1, 2 M2. held: granted cycles completed so far.
    // park: 0 none, else the parked master. last: most recent grantee.
    typedef struct packed {
        int own;
        int held;
        int park;
        bit ok;
        bit terr;
        int last;
    } mstate_t;

    mstate_t ms;

    function automatic mstate_t model_reset();
        mstate_t r;
        r.own = 0; r.held = 0; r.park = 0; r.ok = 1'b0; r.terr = 1'b0; r.last = 2;
        return r;
    endfunction

    function automatic mstate_t model_step(mstate_t s, bit r1, bit r2, bit done,
                                           bit sreq, bit sdone);
        mstate_t n;
        bit e1, e2, hreq;
        n = s;
        n.terr = 1'b0;
        if (sdone && s.park != 0) n.ok = 1'b1;
        if (s.own == 0) begin
            e1 = r1 && (s.park != 1);
            e2 = r2 && (s.park != 2);
            if (s.park != 0 && s.ok) begin
                n.own = s.park; n.park = 0; n.ok = 1'b0;
            end else if (e1 && e2) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
                n.own = (s.last == 1) ? 2 : 1;
`else
                n.own = 1;
`endif
            end else if (e1) begin
                n.own = 1;
            end else if (e2) begin
                n.own = 2;
            end
            if (n.own != 0) begin
                n.held = 0;
                n.last = n.own;
            end
        end else begin
            hreq   = (s.own == 1) ? r1 : r2;
            n.held = s.held + 1;
            if (done) begin
                n.own = 0;
            end else if (sreq && s.park == 0) begin
                n.own = 0; n.park = s.own;
            end else if (!hreq) begin
                n.own = 0;
            end else if (n.held >= Tmo) begin
                n.own = 0; n.terr = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) ms <= model_reset();
        else        ms <= model_step(ms, m1_req, m2_req, m_done, split_req, split_done);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare: {m1_grant, m2_grant, owner, busy, timeout_err}.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cycle", {2'b00, m1_grant, m2_grant, owner, busy, timeout_err},
                {2'b00, ms.own == 1, ms.own == 2, ms.own == 2, ms.own == 1,
                 (ms.own != 0) || (ms.park != 0), ms.terr});
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // -------------------------------------------------------- stimulus ----
    initial begin
        reset = 1'b0;
        m1_req = 1'b0; m2_req = 1'b0; m_done = 1'b0;
        split_req = 1'b0; split_done = 1'b0;

        tick();
        chk("rst_m1_grant", m1_grant, 0);
        chk("rst_m2_grant", m2_grant, 0);
        chk("rst_owner", owner, 0);
        chk("rst_busy", busy, 0);
        chk("rst_terr", timeout_err, 0);
        tick();
        reset = 1'b1;

        // Single M1 transfer.
        tick();
        m1_req = 1'b1;
        tick();
        chk("t1_m1_grant", m1_grant, 1);
        chk("t1_owner", owner, 2'b01);
        chk("t1_busy", busy, 1);
        tick();
        tick();
        m_done = 1'b1; m1_req = 1'b0;
        tick();
        m_done = 1'b0;
        chk("t1_rel_grant", m1_grant, 0);
        chk("t1_rel_busy", busy, 0);

        // Tie after a fresh reset, then a second tie.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        m1_req = 1'b1; m2_req = 1'b1;
        tick();
        chk("tie1_m1", m1_grant, 1);
        chk("tie1_m2_low", m2_grant, 0);
        m_done = 1'b1; m1_req = 1'b0;
        tick();
        m_done = 1'b0; m1_req = 1'b1;
        chk("tie_turnaround", owner, 0);
        tick();
`ifdef BUS_ARB_ROUND_ROBIN_EN
        chk("tie2_m2", m2_grant, 1);
`else
        chk("tie2_m1", m1_grant, 1);
`endif
        m_done = 1'b1; m1_req = 1'b0; m2_req = 1'b0;
        tick();
        m_done = 1'b0;
        chk("tie_rel_busy", busy, 0);

        // Split: park M1, M2 runs, second split ignored, M1 resumes.
        m1_req = 1'b1;
        tick();
        chk("sp_m1", m1_grant, 1);
        split_req = 1'b1; m2_req = 1'b1;
        tick();
        split_req = 1'b0;
        chk("sp_m1_drop", m1_grant, 0);
        chk("sp_busy", busy, 1);
        tick();
        chk("sp_m2", owner, 2'b10);
        split_req = 1'b1;
        tick();
        split_req = 1'b0;
        chk("sp_2nd_ignored", m2_grant, 1);
        split_done = 1'b1;
        tick();
        split_done = 1'b0;
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        chk("sp_idle_owner", owner, 0);
        chk("sp_idle_busy", busy, 1);
        tick();
        chk("sp_regrant_m1", m1_grant, 1);
        chk("sp_regrant_m2_low", m2_grant, 0);
        m_done = 1'b1; m1_req = 1'b0; m2_req = 1'b0;
        tick();
        m_done = 1'b0;
        chk("sp_end_busy", busy, 0);

        // Timeout: M2 holds for Tmo cycles, M1 waiting.
        m2_req = 1'b1;
        tick();
        m1_req = 1'b1;
        for (int i = 0; i < Tmo; i++) begin
            chk("to_m2_held", m2_grant, 1);
            chk("to_no_err", timeout_err, 0);
            tick();
        end
        chk("to_m2_drop", m2_grant, 0);
        chk("to_err", timeout_err, 1);
        tick();
        chk("to_err_once", timeout_err, 0);
        chk("to_m1_next", m1_grant, 1);
        m_done = 1'b1; m1_req = 1'b0; m2_req = 1'b0;
        tick();
        m_done = 1'b0;

        // m_done and split_req together: plain release, nothing parked.
        m1_req = 1'b1;
        tick();
        m_done = 1'b1; split_req = 1'b1; m1_req = 1'b0;
        tick();
        m_done = 1'b0; split_req = 1'b0;
        chk("ds_busy", busy, 0);
        split_done = 1'b1;
        tick();
        split_done = 1'b0;
        chk("ds_busy_still", busy, 0);
        m2_req = 1'b1;
        tick();
        chk("ds_m2_ok", m2_grant, 1);
        m_done = 1'b1; m2_req = 1'b0;
        tick();
        m_done = 1'b0;

        // Asynchronous reset mid-grant.
        m1_req = 1'b1;
        tick();
        chk("ar_m1", m1_grant, 1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("ar_m1_grant", m1_grant, 0);
        chk("ar_m2_grant", m2_grant, 0);
        chk("ar_owner", owner, 0);
        chk("ar_busy", busy, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("ar_restart", m1_grant, 1);
        m_done = 1'b1; m1_req = 1'b0;
        tick();
        m_done = 1'b0;
        tick();
        cmp_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
